// File: rtl/diod_pkg.sv
// Shared definitions for the diode-bias DAC path: arbiter states, DAC word
// width, SPI mode-0 constants and the round-robin selection rule.
package diod_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GUARD = 2'd2
   } arb_state_e;

   localparam int   DAC_WORD_W = 8;
   localparam logic SPI_CPOL   = 1'b0;
   localparam logic SPI_CPHA   = 1'b0;

   // Returns the port to grant; on a tie the port not served last wins.
   function automatic logic rr_pick(input logic r0, input logic r1, input logic last_port);
      if (r0 && r1) begin
         return ~last_port;
      end
      return r1;
   endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 transmitter: clock divider, bit counter and MSB-first shift
// register. 'last' flags the final cycle of the last high half-period.
module spi_tx_shifter
   import diod_pkg::*;
#(
   parameter int DATA_W  = DAC_WORD_W,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] word,
   output logic              spi_clk,
   output logic              spi_mosi,
   output logic              last
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   logic [DIV_W-1:0]  div_q;
   logic [BIT_W-1:0]  bit_q;
   logic [DATA_W-1:0] sreg_q;
   logic              clk_q;
   logic              mosi_q;
   logic              half_end;
   logic              fall;

   assign half_end = (div_q == DIV_LAST);
   assign fall     = half_end && (clk_q != SPI_CPOL);
   assign last     = fall && (bit_q == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         bit_q  <= '0;
         clk_q  <= SPI_CPOL;
         mosi_q <= 1'b0;
      end else if (load) begin
         div_q  <= '0;
         bit_q  <= '0;
         clk_q  <= SPI_CPOL;
         mosi_q <= word[DATA_W-1];
      end else if (shift_en) begin
         if (half_end) begin
            div_q <= '0;
            clk_q <= ~clk_q;
            // Next bit goes out on the falling edge; after the last bit MOSI parks low.
            if (fall) begin
               if (bit_q == BIT_LAST) begin
                  mosi_q <= 1'b0;
               end else begin
                  bit_q  <= bit_q + BIT_W'(1);
                  mosi_q <= sreg_q[DATA_W-2];
               end
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         sreg_q <= word;
      end else if (shift_en && fall && !last) begin
         sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
      end
   end

   assign spi_clk  = clk_q;
   assign spi_mosi = mosi_q;

endmodule

// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter sharing the SPI bias DAC between the sweep path (port 0)
// and the calibration/host path (port 1); one SPI frame per grant.
module dac_spi_arbiter
   import diod_pkg::*;
#(
   parameter int DATA_W  = DAC_WORD_W,
   parameter int CLK_DIV = 4,
   parameter int GUARD   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              busy,
   output logic              spi_clk,
   output logic              spi_mosi,
   output logic              spi_ss,
   output logic [1:0]        debug_state
);

   localparam int GRD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
   localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'((GUARD > 0) ? GUARD - 1 : 0);

   arb_state_e       state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic             ss_q, ss_d;
   logic             busy_q, busy_d;
   logic [GRD_W-1:0] grd_q, grd_d;
   logic             load;
   logic             shift_en;
   logic             pick;
   logic             last;
   logic [DATA_W-1:0] word_sel;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt0_d   = gnt0_q;
      gnt1_d   = gnt1_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      ss_d     = ss_q;
      grd_d    = grd_q;
      load     = 1'b0;
      shift_en = 1'b0;
      pick     = rr_pick(req0, req1, ptr_q);
      unique case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               load    = 1'b1;
               gnt0_d  = ~pick;
               gnt1_d  = pick;
               ss_d    = 1'b0;
               ptr_d   = pick;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            // Frame end: release the bus and pulse done in the same cycle.
            if (last) begin
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               done0_d = gnt0_q;
               done1_d = gnt1_q;
               ss_d    = 1'b1;
               grd_d   = '0;
               state_d = (GUARD == 0) ? ST_IDLE : ST_GUARD;
            end
         end
         ST_GUARD: begin
            if (grd_q == GRD_LAST) begin
               state_d = ST_IDLE;
            end else begin
               grd_d = grd_q + GRD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         ss_q    <= 1'b1;
         busy_q  <= 1'b0;
         grd_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         ss_q    <= ss_d;
         busy_q  <= busy_d;
         grd_q   <= grd_d;
      end
   end

   assign word_sel = pick ? data1 : data0;

   spi_tx_shifter #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk      (clk),
      .rst_n    (reset),
      .load     (load),
      .shift_en (shift_en),
      .word     (word_sel),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .last     (last)
   );

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign busy        = busy_q;
   assign spi_ss      = ss_q;
   assign debug_state = state_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Directed bench for dac_spi_arbiter: default-parameter instance plus a
// CLK_DIV=1 / GUARD=0 instance, checked against hand-computed frame timing.
module tb_dac_spi_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, req0, req1;
   logic [7:0] data0, data1;
   logic       gnt0, gnt1, done0, done1, busy, spi_clk, spi_mosi, spi_ss;
   logic [1:0] debug_state;

   logic       f_req0, f_req1;
   logic [7:0] f_data0, f_data1;
   logic       f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_spi_clk, f_spi_mosi, f_spi_ss;
   logic [1:0] f_debug_state;

   dac_spi_arbiter #(.DATA_W(8), .CLK_DIV(4), .GUARD(2)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
      .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_ss(spi_ss), .debug_state(debug_state)
   );

   dac_spi_arbiter #(.DATA_W(8), .CLK_DIV(1), .GUARD(0)) dut_f (
      .clk(clk), .reset(reset), .req0(f_req0), .req1(f_req1), .data0(f_data0), .data1(f_data1),
      .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1), .busy(f_busy),
      .spi_clk(f_spi_clk), .spi_mosi(f_spi_mosi), .spi_ss(f_spi_ss), .debug_state(f_debug_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         rx_total = 0;
   logic [7:0] rx_win   = 8'h00;
   always @(posedge spi_clk) begin
      rx_win = {rx_win[6:0], spi_mosi};
      rx_total++;
   end

   int         f_rx_total = 0;
   logic [7:0] f_rx_win   = 8'h00;
   always @(posedge f_spi_clk) begin
      f_rx_win = {f_rx_win[6:0], f_spi_mosi};
      f_rx_total++;
   end

   int   ovl = 0, d0_cnt = 0, d1_cnt = 0, d0_cyc = 0, d1_cyc = 0, ss_run = 0, rise_n = 0;
   int   rise_who [0:31];
   int   rise_cyc [0:31];
   int   rise_gap [0:31];
   logic g0_prev = 1'b0, g1_prev = 1'b0;
   always @(negedge clk) begin
      if (gnt0 && gnt1) ovl++;
      if (done0 && done1) ovl++;
      if (done0) begin d0_cnt++; d0_cyc = cyc; end
      if (done1) begin d1_cnt++; d1_cyc = cyc; end
      if ((gnt0 && !g0_prev) || (gnt1 && !g1_prev)) begin
         if (rise_n < 32) begin
            rise_who[rise_n] = gnt1 ? 1 : 0;
            rise_cyc[rise_n] = cyc;
            rise_gap[rise_n] = ss_run;
         end
         rise_n++;
      end
      ss_run  = spi_ss ? ss_run + 1 : 0;
      g0_prev = gnt0;
      g1_prev = gnt1;
   end

   int   f_ovl = 0, f_done_cyc = 0, f_rise_n = 0;
   int   f_rise_cyc [0:31];
   logic fg0_prev = 1'b0;
   always @(negedge clk) begin
      if (f_gnt0 && f_gnt1) f_ovl++;
      if (f_done0 && f_done1) f_ovl++;
      if (f_done0) f_done_cyc = cyc;
      if (f_gnt0 && !fg0_prev) begin
         if (f_rise_n < 32) f_rise_cyc[f_rise_n] = cyc;
         f_rise_n++;
      end
      fg0_prev = f_gnt0;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic sel_sig(input int which);
      case (which)
         0:       return done0;
         1:       return done1;
         2:       return gnt0;
         3:       return gnt1;
         default: return f_done0;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int which, input int limit);
      int n = 0;
      while (!sel_sig(which) && n < limit) begin
         step();
         n++;
      end
      if (!sel_sig(which)) chk({tag, "_timeout"}, {31'd0, sel_sig(which)}, 1);
   endtask

   int mark, r0, r1, dc, c0, fr;

   initial begin
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
      f_req0 = 1'b0; f_req1 = 1'b0; f_data0 = 8'h00; f_data1 = 8'h00;
      repeat (3) step();
      chk("rst_ss", spi_ss, 1);
      chk("rst_sclk", spi_clk, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_done", {done1, done0}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", debug_state, 0);
      reset = 1'b1;
      step();

      // Single request, 0xA5
      r0 = rise_n; mark = rx_total; c0 = cyc;
      data0 = 8'hA5; req0 = 1'b1;
      wait_sig("a_gnt", 2, 10);
      chk("a_lat", rise_cyc[r0], c0 + 1);
      chk("a_gnt0", gnt0, 1);
      chk("a_gnt1", gnt1, 0);
      chk("a_ss_lo", spi_ss, 0);
      chk("a_mosi_msb", spi_mosi, 1);
      chk("a_state", debug_state, 1);
      chk("a_busy", busy, 1);
      wait_sig("a_done", 0, 100);
      req0 = 1'b0;
      chk("a_len", d0_cyc - rise_cyc[r0], 64);
      chk("a_rx", rx_win, 8'hA5);
      chk("a_bits", rx_total - mark, 8);
      chk("a_gnt_fall", gnt0, 0);
      chk("a_ss_hi", spi_ss, 1);
      chk("a_sclk_lo", spi_clk, 0);
      chk("a_mosi_lo", spi_mosi, 0);
      step();
      chk("a_done_pulse", done0, 0);
      chk("a_guard_state", debug_state, 2);
      step();
      chk("a_ss_guard", spi_ss, 1);
      chk("a_done_cnt", d0_cnt, 1);

      // Simultaneous first request after reset
      reset = 1'b0; step(); step(); reset = 1'b1; step();
      r0 = rise_n; mark = rx_total;
      data0 = 8'h11; data1 = 8'hEE; req0 = 1'b1; req1 = 1'b1;
      wait_sig("b_done0", 0, 100);
      req0 = 1'b0;
      chk("b_first_who", rise_who[r0], 0);
      chk("b_rx0", rx_win, 8'h11);
      chk("b_bits0", rx_total - mark, 8);
      mark = rx_total;
      wait_sig("b_done1", 1, 100);
      req1 = 1'b0;
      chk("b_second_who", rise_who[r0 + 1], 1);
      chk("b_done_gap", d1_cyc - d0_cyc, 67);
      chk("b_rx1", rx_win, 8'hEE);
      chk("b_bits1", rx_total - mark, 8);

      // Continuous contention for four frames
      repeat (5) step();
      r0 = rise_n;
      data0 = 8'h3C; data1 = 8'hC3; req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) wait_sig($sformatf("c_done%0d", i), i % 2, 100);
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 4; k++) chk($sformatf("c_who%0d", k), rise_who[r0 + k], k % 2);
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("c_period%0d", k), rise_cyc[r0 + k] - rise_cyc[r0 + k - 1], 67);
         chk($sformatf("c_ss_gap%0d", k), rise_gap[r0 + k], 3);
      end

      // Reset in the middle of bit 3
      repeat (5) step();
      data0 = 8'h3C; req0 = 1'b1;
      wait_sig("d_gnt", 2, 10);
      repeat (3 * 8 + 2) step();
      dc = d0_cnt;
      reset = 1'b0;
      #1;
      chk("d_ss", spi_ss, 1);
      chk("d_sclk", spi_clk, 0);
      chk("d_mosi", spi_mosi, 0);
      chk("d_gnt", gnt0, 0);
      chk("d_busy", busy, 0);
      chk("d_state", debug_state, 0);
      step(); step();
      chk("d_no_done", d0_cnt, dc);
      data0 = 8'h5A; r1 = rise_n; mark = rx_total;
      reset = 1'b1;
      wait_sig("d_done", 0, 100);
      req0 = 1'b0;
      chk("d_rx", rx_win, 8'h5A);
      chk("d_bits", rx_total - mark, 8);
      chk("d_len", d0_cyc - rise_cyc[r1], 64);
      chk("d_done_cnt", d0_cnt, dc + 1);

      // Request 1 withdrawn at bit 2
      repeat (5) step();
      r1 = rise_n; mark = rx_total; dc = d1_cnt;
      data1 = 8'h96; req1 = 1'b1;
      wait_sig("e_gnt", 3, 10);
      repeat (2 * 8 + 2) step();
      req1 = 1'b0;
      wait_sig("e_done", 1, 100);
      chk("e_rx", rx_win, 8'h96);
      chk("e_bits", rx_total - mark, 8);
      chk("e_len", d1_cyc - rise_cyc[r1], 64);
      repeat (80) step();
      chk("e_no_regrant", rise_n, r1 + 1);
      chk("e_done_cnt", d1_cnt, dc + 1);
      chk("overlap", ovl, 0);

      // Fastest parameters: CLK_DIV=1, GUARD=0
      fr = f_rise_n; mark = f_rx_total;
      f_data0 = 8'hC3; f_req0 = 1'b1;
      step();
      chk("f_gnt", f_gnt0, 1);
      chk("f_ss_lo", f_spi_ss, 0);
      chk("f_busy", f_busy, 1);
      chk("f_state", f_debug_state, 1);
      wait_sig("f_done0", 4, 40);
      chk("f_len", f_done_cyc - f_rise_cyc[fr], 16);
      chk("f_rx", f_rx_win, 8'hC3);
      chk("f_bits", f_rx_total - mark, 8);
      chk("f_ss_hi", f_spi_ss, 1);
      step();
      wait_sig("f_done1", 4, 40);
      step();
      wait_sig("f_done2", 4, 40);
      f_req0 = 1'b0;
      chk("f_period1", f_rise_cyc[fr + 1] - f_rise_cyc[fr], 17);
      chk("f_period2", f_rise_cyc[fr + 2] - f_rise_cyc[fr + 1], 17);
      chk("f_overlap", f_ovl, 0);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dac_spi_arbiter.md
# dac_spi_arbiter

Shares the single SPI bias DAC between two requesters: port 0 is the diode bias controller's sweep path, port 1 is the calibration/host write path. The block arbitrates round-robin and serialises the granted 8-bit word as one SPI mode-0 frame. It reports completion back to the requester. It sits between the requesters and the DAC pins, and owns `spi_clk`, `spi_mosi` and `spi_ss`.

## Interface
- `DATA_W`, 8: bits per SPI frame, MSB first.
- `CLK_DIV`, 4: system clocks per SPI half-period. Must be ≥ 1.
- `GUARD`, 2: extra cycles `spi_ss` stays high between frames. Must be ≥ 0.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request; held high until the matching `done`.
- `data0`, `data1`  in  DATA_W  word to send; must be stable while `req` is high.
- `gnt0`, `gnt1`  out  1  high for the whole frame owned by that port.
- `done0`, `done1`  out  1  one-cycle pulse when the frame ends.
- `busy`  out  1  high in SHIFT and GUARD.
- `spi_clk`  out  1  SPI clock; idles low.
- `spi_mosi`  out  1  serial data.
- `spi_ss`  out  1  chip select, active low.
- `debug_state`  out  2  state encoding: IDLE=0, SHIFT=1, GUARD=2.

## Operation
- **States:** IDLE, SHIFT and GUARD.
- **IDLE:**
  - With no request, stay in IDLE.
  - With one request, grant that port.
  - With both requests, grant the port not served last. The last-served pointer resets to 1, so `req0` wins the first tie.
  - On a grant: latch `dataN` into the shift register, set `gntN`=1 and `spi_ss`=0, drive `spi_mosi` with the MSB, update the pointer, and go to SHIFT.
- **SHIFT:**
  - Each bit is `CLK_DIV` cycles with `spi_clk` low, then `CLK_DIV` cycles high.
  - The next bit is presented when `spi_clk` falls. The DAC samples on the rising edge (mode 0).
  - After the last high half-period, in the same cycle: `spi_clk`=0, `spi_ss`=1, `spi_mosi`=0, `gntN`=0, `doneN`=1 for one cycle. Then go to GUARD, or straight to IDLE when `GUARD`=0.
- **GUARD:**
  - Count `GUARD` cycles, then go to IDLE.
  - Requests are not sampled in GUARD.
- **Request withdrawn mid-frame:** ignored. The frame completes and `done` still pulses.
- **Request still high at `done`:** treated as a new request at the next IDLE. Round-robin still applies.
- **Widths:**
  - Bit counter: `$clog2(DATA_W)`.
  - Divider counter: `$clog2(CLK_DIV)`, minimum 1 bit.
  - Guard counter: `$clog2(GUARD+1)`.
  - No counter wraps past its terminal value.
- **Reset values**, asserted immediately on `reset`=0, including mid-frame:
  - `spi_ss`=1; `spi_clk`=0, `spi_mosi`=0.
  - `gnt0`/`gnt1`=0, `done0`/`done1`=0.
  - `busy`=0; `debug_state`=IDLE; pointer=1.
  - An aborted frame produces no `done`.

## Timing
- **Grant latency:** with `req` high before edge k in IDLE, `gnt` and `spi_ss`=0 appear after edge k.
- **Frame length:** `done` pulses exactly `DATA_W*2*CLK_DIV` cycles after `gnt` rises (64 at the defaults). This is the same cycle as `gnt` falling and `spi_ss` rising.
- **Inter-frame gap:** `spi_ss` stays high for at least `GUARD`+1 cycles between frames (3 at the defaults).
- **Back-to-back throughput:** one frame per `DATA_W*2*CLK_DIV+GUARD+1` cycles.
- **Output timing:** all outputs are registered; there is no combinational path from `req` to a pin.
- **Exclusivity:** `gnt0` and `gnt1` are never high together. `done0` and `done1` are never high together.

## Structure
- **Shared package `diod_pkg`:**
  - state enum: IDLE, SHIFT, GUARD;
  - `DAC_WORD_W`=8;
  - SPI mode-0 constants (CPOL=0, CPHA=0).
- **Sub-module `spi_tx_shifter`:** divider, bit counter and shift register.
  - Inputs: `load`, `word`.
  - Outputs: `spi_clk`, `spi_mosi`, `last`.
  - The arbiter FSM and round-robin pointer stay in the top level.

## Test plan
- **Single request:** `req0` with `data0`=0xA5 → `gnt0` for 64 cycles; MOSI sampled on 8 rising `spi_clk` edges = 1,0,1,0,0,1,0,1; `done0` one cycle; `spi_ss` high for ≥3 cycles afterwards.
- **Simultaneous first request:** `req0` and `req1` rise together right after reset, with 0x11 and 0xEE → the 0x11 frame then the 0xEE frame; `done0` is 67 cycles before `done1`.
- **Continuous contention:** both requests held high for 4 frames → grants alternate 0,1,0,1; `gnt0` and `gnt1` never overlap.
- **Reset mid-frame:** `reset` low at bit 3 of a frame → `spi_ss`=1, `spi_clk`=0 in the same cycle; no `done`; the next frame after reset is complete and correct.
- **Request dropped mid-frame:** `req1` drops at bit 2 → all 8 bits are sent and `done1` pulses; no second grant follows.
- **Fastest parameters:** `CLK_DIV`=1, `GUARD`=0 → frame = 16 cycles; back-to-back `req0` frames start every 17 cycles.
